game_countdown_timer: RTL and testbench

//  Consumes the 100 ms tick from the upstream LFSR tick generator and runs a BCD countdown
//  of SS.t (seconds 00-99, tenths 0-9) for the game round. Drives the generator's enable so

---
 rtl/game_countdown_timer.sv | 170 +++++++++++++++++
 tb/tb_game_countdown_timer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_countdown_timer.sv
// rtl/game_countdown_timer.sv - BCD SS.t round countdown driven by an external 100 ms tick (optional warn: TIMER_WARN_EN)
module game_countdown_timer #(
    parameter logic [7:0] INIT_SEC = 8'h30,
    parameter logic [7:0] WARN_SEC = 8'h05
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_load,
    input  logic [7:0] i_load_sec,
    input  logic       i_tick_100ms,
    output logic       o_tick_en,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_sec_ones,
    output logic [3:0] o_tenths,
    output logic       o_running,
    output logic       o_timeout,
    output logic       o_done,
    output logic       o_warn
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [3:0] r_tens, r_ones, r_tenths;
    logic [3:0] w_tens_nxt, w_ones_nxt, w_tenths_nxt;
    logic       r_timeout;

    logic [3:0] w_load_tens, w_load_ones;
    logic [3:0] w_dec_tens, w_dec_ones, w_dec_tenths;
    logic       w_digits_zero;
    logic       w_dec_zero;
    logic       w_tick_taken;

    // Out-of-range BCD nibbles saturate to 9 so the counter never holds an illegal digit
    assign w_load_tens = (i_load_sec[7:4] > 4'd9) ? 4'd9 : i_load_sec[7:4];
    assign w_load_ones = (i_load_sec[3:0] > 4'd9) ? 4'd9 : i_load_sec[3:0];

    assign w_digits_zero = (r_tens == 4'd0) && (r_ones == 4'd0) && (r_tenths == 4'd0);
    assign w_dec_zero    = (r_tens == 4'd0) && (r_ones == 4'd0) && (r_tenths == 4'd1);
    assign w_tick_taken  = (r_state == S_RUN) && !i_pause && i_tick_100ms;

    // One-tenth BCD decrement with borrow ripple tenths -> ones -> tens
    always_comb begin
        w_dec_tenths = r_tenths - 4'd1;
        w_dec_ones   = r_ones;
        w_dec_tens   = r_tens;
        if (r_tenths == 4'd0) begin
            w_dec_tenths = 4'd9;
            w_dec_ones   = r_ones - 4'd1;
            if (r_ones == 4'd0) begin
                w_dec_ones = 4'd9;
                w_dec_tens = r_tens - 4'd1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: load > pause > start > tick; RUN ignores load/start
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_PAUSED: begin
                if (i_load) begin
                    w_next_state = r_state;
                end else if (i_pause) begin
                    w_next_state = r_state;
                end else if (i_start) begin
                    w_next_state = w_digits_zero ? S_EXPIRED : S_RUN;
                end
            end
            S_RUN: begin
                if (i_pause) begin
                    w_next_state = S_PAUSED;
                end else if (i_tick_100ms && w_dec_zero) begin
                    w_next_state = S_EXPIRED;
                end
            end
            S_EXPIRED: begin
                if (i_load) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs decoded straight from state so they track it with no extra latency
    always_comb begin
        o_tick_en = 1'b0;
        o_running = 1'b0;
        o_done    = 1'b0;
        case (r_state)
            S_RUN: begin
                o_tick_en = 1'b1;
                o_running = 1'b1;
            end
            S_EXPIRED: o_done = 1'b1;
            default: ;
        endcase
    end

    // Next digit values: load outside RUN, decrement on an accepted tick in RUN
    always_comb begin
        w_tens_nxt   = r_tens;
        w_ones_nxt   = r_ones;
        w_tenths_nxt = r_tenths;
        if (r_state != S_RUN && i_load) begin
            w_tens_nxt   = w_load_tens;
            w_ones_nxt   = w_load_ones;
            w_tenths_nxt = 4'd0;
        end else if (w_tick_taken) begin
            w_tens_nxt   = w_dec_tens;
            w_ones_nxt   = w_dec_ones;
            w_tenths_nxt = w_dec_tenths;
        end
    end

    // Digit registers and the single-cycle timeout pulse on entry to EXPIRED
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tens    <= INIT_SEC[7:4];
            r_ones    <= INIT_SEC[3:0];
            r_tenths  <= 4'd0;
            r_timeout <= 1'b0;
        end else begin
            r_tens    <= w_tens_nxt;
            r_ones    <= w_ones_nxt;
            r_tenths  <= w_tenths_nxt;
            r_timeout <= (w_next_state == S_EXPIRED) && (r_state != S_EXPIRED);
        end
    end

`ifdef TIMER_WARN_EN
    logic r_warn;

    // Warn registered alongside the digits; packed BCD compares correctly as binary
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_warn <= 1'b0;
        end else begin
            r_warn <= ((w_next_state == S_RUN) || (w_next_state == S_PAUSED)) &&
                      ({w_tens_nxt, w_ones_nxt} < WARN_SEC);
        end
    end

    assign o_warn = r_warn;
`else
    assign o_warn = 1'b0;
`endif

    assign o_sec_tens = r_tens;
    assign o_sec_ones = r_ones;
    assign o_tenths   = r_tenths;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_game_countdown_timer.sv
// tb/tb_game_countdown_timer.sv - directed self-checking bench for game_countdown_timer
`timescale 1ns/1ps
module tb_game_countdown_timer;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_pause;
    logic       i_load;
    logic [7:0] i_load_sec;
    logic       i_tick_100ms;
    logic       o_tick_en;
    logic [3:0] o_sec_tens;
    logic [3:0] o_sec_ones;
    logic [3:0] o_tenths;
    logic       o_running;
    logic       o_timeout;
    logic       o_done;
    logic       o_warn;

    int checks;
    int failures;

    game_countdown_timer #(.INIT_SEC(8'h30), .WARN_SEC(8'h05)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_pause      (i_pause),
        .i_load       (i_load),
        .i_load_sec   (i_load_sec),
        .i_tick_100ms (i_tick_100ms),
        .o_tick_en    (o_tick_en),
        .o_sec_tens   (o_sec_tens),
        .o_sec_ones   (o_sec_ones),
        .o_tenths     (o_tenths),
        .o_running    (o_running),
        .o_timeout    (o_timeout),
        .o_done       (o_done),
        .o_warn       (o_warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        i_load = 1'b1; i_load_sec = v;
        step();
        i_load = 1'b0;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            i_tick_100ms = 1'b1;
            step();
            i_tick_100ms = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths} !== 12'h300) begin
            failures++; $display("FAIL reset_digits got=%h exp=300", {o_sec_tens, o_sec_ones, o_tenths});
        end
        checks++;
        if ({o_tick_en, o_running, o_timeout, o_done, o_warn} !== 5'b00000) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {o_tick_en, o_running, o_timeout, o_done, o_warn});
        end
    endtask

    task automatic test_expiry();
        logic [11:0] exp_d;
        int rem;
        do_load(8'h01);
        do_start();
        checks++;
        if ({o_running, o_tick_en} !== 2'b11) begin
            failures++; $display("FAIL expiry_run got=%b exp=11", {o_running, o_tick_en});
        end
        for (int k = 1; k <= 10; k++) begin
            do_ticks(1);
            rem = 10 - k;
            exp_d = {4'd0, 4'(rem / 10), 4'(rem % 10)};
            checks++;
            if ({o_sec_tens, o_sec_ones, o_tenths} !== exp_d) begin
                failures++; $display("FAIL expiry_digits tick=%0d got=%h exp=%h", k, {o_sec_tens, o_sec_ones, o_tenths}, exp_d);
            end
            checks++;
            if (o_timeout !== (k == 10)) begin
                failures++; $display("FAIL expiry_timeout tick=%0d got=%b exp=%b", k, o_timeout, (k == 10));
            end
        end
        checks++;
        if ({o_done, o_tick_en, o_running} !== 3'b100) begin
            failures++; $display("FAIL expiry_state got=%b exp=100", {o_done, o_tick_en, o_running});
        end
        do_ticks(3);
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths, o_done, o_timeout} !== {12'h000, 2'b10}) begin
            failures++; $display("FAIL expiry_hold got=%h done=%b to=%b exp=000 1 0", {o_sec_tens, o_sec_ones, o_tenths}, o_done, o_timeout);
        end
    endtask

    task automatic test_borrow_clamp();
        do_load(8'h10);
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths, o_done} !== {12'h100, 1'b0}) begin
            failures++; $display("FAIL load_from_expired got=%h done=%b exp=100 0", {o_sec_tens, o_sec_ones, o_tenths}, o_done);
        end
        do_start();
        do_ticks(1);
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths} !== 12'h099) begin
            failures++; $display("FAIL double_borrow got=%h exp=099", {o_sec_tens, o_sec_ones, o_tenths});
        end
        do_reset();
        do_load(8'hA7);
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths} !== 12'h970) begin
            failures++; $display("FAIL clamp got=%h exp=970", {o_sec_tens, o_sec_ones, o_tenths});
        end
        i_load = 1'b1; i_start = 1'b1; i_load_sec = 8'h2C;
        step();
        i_load = 1'b0; i_start = 1'b0;
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths, o_running} !== {12'h290, 1'b0}) begin
            failures++; $display("FAIL load_start_prio got=%h run=%b exp=290 0", {o_sec_tens, o_sec_ones, o_tenths}, o_running);
        end
    endtask

    task automatic test_pause();
        do_load(8'h06);
        do_start();
        do_ticks(7);
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths} !== 12'h053) begin
            failures++; $display("FAIL pause_pre got=%h exp=053", {o_sec_tens, o_sec_ones, o_tenths});
        end
        i_pause = 1'b1; i_tick_100ms = 1'b1;
        step();
        i_pause = 1'b0; i_tick_100ms = 1'b0;
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths, o_running, o_tick_en} !== {12'h053, 2'b00}) begin
            failures++; $display("FAIL pause_tick_same got=%h run=%b en=%b exp=053 0 0", {o_sec_tens, o_sec_ones, o_tenths}, o_running, o_tick_en);
        end
        do_ticks(3);
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths} !== 12'h053) begin
            failures++; $display("FAIL paused_ticks got=%h exp=053", {o_sec_tens, o_sec_ones, o_tenths});
        end
        do_start();
        checks++;
        if (o_running !== 1'b1) begin
            failures++; $display("FAIL resume got=%b exp=1", o_running);
        end
        do_ticks(1);
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths} !== 12'h052) begin
            failures++; $display("FAIL resume_tick got=%h exp=052", {o_sec_tens, o_sec_ones, o_tenths});
        end
    endtask

    task automatic test_zero_start_and_abort();
        do_reset();
        do_load(8'h00);
        do_start();
        checks++;
        if ({o_done, o_timeout, o_running} !== 3'b110) begin
            failures++; $display("FAIL zero_start got=%b exp=110", {o_done, o_timeout, o_running});
        end
        do_start();
        checks++;
        if ({o_done, o_timeout, o_running} !== 3'b100) begin
            failures++; $display("FAIL zero_start_after got=%b exp=100", {o_done, o_timeout, o_running});
        end
        do_load(8'h13);
        do_start();
        do_ticks(6);
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths} !== 12'h124) begin
            failures++; $display("FAIL abort_pre got=%h exp=124", {o_sec_tens, o_sec_ones, o_tenths});
        end
        rst = 1'b0; i_tick_100ms = 1'b1;
        step();
        i_tick_100ms = 1'b0;
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths, o_running, o_timeout, o_done} !== {12'h300, 3'b000}) begin
            failures++; $display("FAIL abort got=%h flags=%b exp=300 000", {o_sec_tens, o_sec_ones, o_tenths}, {o_running, o_timeout, o_done});
        end
        rst = 1'b1;
        step();
        checks++;
        if ({o_running, o_timeout} !== 2'b00) begin
            failures++; $display("FAIL abort_after got=%b exp=00", {o_running, o_timeout});
        end
    endtask

    task automatic test_warn();
        logic exp_w;
        do_reset();
        do_load(8'h06);
        do_start();
        do_ticks(9);
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths, o_warn} !== {12'h051, 1'b0}) begin
            failures++; $display("FAIL warn_pre got=%h w=%b exp=051 0", {o_sec_tens, o_sec_ones, o_tenths}, o_warn);
        end
        do_ticks(1);
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths, o_warn} !== {12'h050, 1'b0}) begin
            failures++; $display("FAIL warn_050 got=%h w=%b exp=050 0", {o_sec_tens, o_sec_ones, o_tenths}, o_warn);
        end
        do_ticks(1);
`ifdef TIMER_WARN_EN
        exp_w = 1'b1;
`else
        exp_w = 1'b0;
`endif
        checks++;
        if ({o_sec_tens, o_sec_ones, o_tenths, o_warn} !== {12'h049, exp_w}) begin
            failures++; $display("FAIL warn_049 got=%h w=%b exp=049 %b", {o_sec_tens, o_sec_ones, o_tenths}, o_warn, exp_w);
        end
        do_ticks(49);
        checks++;
        if ({o_done, o_timeout, o_warn} !== 3'b110) begin
            failures++; $display("FAIL warn_expiry got=%b exp=110", {o_done, o_timeout, o_warn});
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_load = 1'b0;
        i_load_sec = 8'h00; i_tick_100ms = 1'b0;
        test_reset();
        test_expiry();
        test_borrow_clamp();
        test_pause();
        test_zero_start_and_abort();
        test_warn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
